// File: rtl/rr_burst_arbiter_if.sv
// Request/grant bundle between five masters and the round-robin burst arbiter.
// The urgent line exists only when ARB_URGENT_EN is defined.
interface rr_burst_arbiter_if #(
    parameter int N_REQ = 5,
    parameter int CNT_W = 4
);
`ifdef ARB_URGENT_EN
    logic             urgent;
`endif
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             gnt_vld;
    logic [2:0]       gnt_id;
    logic [CNT_W-1:0] burst_cnt;

    // master: the requester side; slave: the arbiter side
    modport master (
`ifdef ARB_URGENT_EN
        output urgent,
`endif
        output req,
        input  gnt, gnt_vld, gnt_id, burst_cnt
    );

    modport slave (
`ifdef ARB_URGENT_EN
        input  urgent,
`endif
        input  req,
        output gnt, gnt_vld, gnt_id, burst_cnt
    );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Five-requester round-robin arbiter with bounded ownership bursts and fully registered grant.
// Optional macro ARB_URGENT_EN adds an urgent input that preempts in favour of requester 4.
module rr_burst_arbiter #(
    parameter int N_REQ     = 5,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    rr_burst_arbiter_if.slave bus
);

    typedef enum logic {IDLE, OWN} state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } hit_t;

    localparam logic [2:0]       LAST     = 3'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             gnt_vld_q;
    logic [2:0]       id_q, id_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    hit_t             hit;
    logic             take;
    logic [2:0]       win;

    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (i == LAST) ? 3'd0 : i + 3'd1;
    endfunction

    // First set request at or after start, wrapping; start itself is checked first.
    function automatic hit_t search(input logic [N_REQ-1:0] r, input logic [2:0] start);
        hit_t       h;
        logic [2:0] idx;
        h   = '0;
        idx = start;
        for (int k = 0; k < N_REQ; k++) begin
            if (!h.found && r[idx]) begin
                h.found = 1'b1;
                h.idx   = idx;
            end
            idx = next_idx(idx);
        end
        return h;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [2:0] i);
        return N_REQ'(1) << i;
    endfunction

    // rr_ptr always equals the current or most recent owner, so one search serves every case.
    always_comb begin
        hit = search(bus.req, next_idx(ptr_q));
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        win     = hit.idx;

        case (state_q)
            IDLE: begin
                take = hit.found;
            end
            OWN: begin
                if (bus.req[id_q] && (cnt_q < CNT_LAST)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (hit.found) begin
                    take = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase

`ifdef ARB_URGENT_EN
        if (bus.urgent && bus.req[LAST]) begin
            take = 1'b1;
            win  = LAST;
        end
`endif

        if (take) begin
            state_d = OWN;
            gnt_d   = onehot(win);
            id_d    = win;
            ptr_d   = win;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            id_q      <= 3'd0;
            ptr_q     <= LAST;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= |gnt_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_vld   = gnt_vld_q;
    assign bus.gnt_id    = id_q;
    assign bus.burst_cnt = cnt_q;

endmodule
